// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
// Optional build macro: INST_LOADER_CHECKSUM_EN adds the trailing checksum state.
package inst_loader_pkg;

  localparam int HDR_BYTES         = 4;
  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WR_LAST,
`ifdef INST_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master modport is the loader side; the slave modport is the UART/memory side.
interface inst_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_di;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_di
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/inst_loader_word_assembler.sv
// Little-endian byte-to-word packer; word_o/wordValid_o are valid in the cycle
// the final byte is presented, so the caller can act without an extra stage.
module word_assembler
  import inst_loader_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_WORD
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear_i,
  input  logic                byteValid_i,
  input  logic [7:0]          byte_i,
  output logic                wordValid_o,
  output logic [NBYTES*8-1:0] word_o
);

  localparam int IDX_W  = $clog2(NBYTES);
  localparam int PACK_W = (NBYTES - 1) * 8;

  logic [PACK_W-1:0] pack_q, pack_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Bytes shift in from the top so the first byte ends up in the low lane.
  always_comb begin
    pack_d = pack_q;
    idx_d  = idx_q;
    if (clear_i) begin
      pack_d = '0;
      idx_d  = '0;
    end else if (byteValid_i) begin
      pack_d = {byte_i, pack_q[PACK_W-1:8]};
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pack_q <= '0;
      idx_q  <= '0;
    end else begin
      pack_q <= pack_d;
      idx_q  <= idx_d;
    end
  end

  assign wordValid_o = byteValid_i && (idx_q == IDX_W'(NBYTES - 1));
  assign word_o      = {byte_i, pack_q};

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed program from a UART byte stream into instruction memory.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  inst_loader_if.master        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  state_e            state_q, state_d;
  logic [31:0]       numWords_q, numWords_d;
  logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [31:0]       memDi_q, memDi_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        rxReady, accept, startLoad;
  logic        hdrValid, dataValid;
  logic [31:0] hdrWord, dataWord;

  assign rxReady   = (state_q == HDR) || (state_q == DATA)
`ifdef INST_LOADER_CHECKSUM_EN
                   || (state_q == CSUM)
`endif
                   ;
  assign accept    = bus.rx_valid && rxReady;
  assign startLoad = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  word_assembler #(.NBYTES(HDR_BYTES)) u_hdr (
    .clk(clk), .rstn(rstn), .clear_i(startLoad),
    .byteValid_i(accept && (state_q == HDR)), .byte_i(bus.rx_data),
    .wordValid_o(hdrValid), .word_o(hdrWord)
  );

  word_assembler #(.NBYTES(BYTES_PER_WORD)) u_data (
    .clk(clk), .rstn(rstn), .clear_i(startLoad),
    .byteValid_i(accept && (state_q == DATA)), .byte_i(bus.rx_data),
    .wordValid_o(dataValid), .word_o(dataWord)
  );

  always_comb begin
    state_d    = state_q;
    numWords_d = numWords_q;
    wordCnt_d  = wordCnt_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memDi_d    = memDi_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = HDR;
          wordCnt_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      HDR: begin
        if (hdrValid) begin
          numWords_d = hdrWord;
          if (hdrWord == 32'd0)
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          else if (hdrWord > 32'(MAX_WORDS))
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ bus.rx_data;
`endif
        // The write is registered so mem_di stays stable while the next word streams in.
        if (dataValid) begin
          memWe_d   = 1'b1;
          memAddr_d = wordCnt_q[ADDR_W-1:0];
          memDi_d   = dataWord;
          wordCnt_d = wordCnt_q + 1'b1;
          if (32'(wordCnt_q) + 32'd1 == numWords_q) state_d = WR_LAST;
        end
      end
      WR_LAST: begin
`ifdef INST_LOADER_CHECKSUM_EN
        state_d = CSUM;
`else
        state_d = DONE;
`endif
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (bus.rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      numWords_q <= '0;
      wordCnt_q  <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memDi_q    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      numWords_q <= numWords_d;
      wordCnt_q  <= wordCnt_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memDi_q    <= memDi_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.rx_ready = rxReady;
  assign bus.mem_we   = memWe_q;
  assign bus.mem_addr = memAddr_q;
  assign bus.mem_di   = memDi_q;
  assign busy  = rxReady || (state_q == WR_LAST);
  assign done  = (state_q == DONE);
  assign error = (state_q == ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: header/data loads, boundaries, gaps, reset abort
// and, when INST_LOADER_CHECKSUM_EN is defined, checksum accept/reject.
module tb_inst_loader;

  localparam int ADDR_W = 10;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus();

  inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
    .clk(clk), .rstn(rstn), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vecCnt  = 0;
  int missCnt = 0;
  int weRepeat = 0;
  logic prevWe = 1'b0;
  logic [ADDR_W-1:0] weAddr[$];
  logic [31:0]       weData[$];
  logic [7:0]        benchCsum;

  // Every sampled mem_we=1 is one memory write; consecutive highs mean a stretched pulse.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      weAddr.push_back(bus.mem_addr);
      weData.push_back(bus.mem_di);
      if (prevWe) weRepeat++;
    end
    prevWe = (bus.mem_we === 1'b1);
  end

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waitCnt = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.rx_ready !== 1'b1) begin
      vecCnt++;
      missCnt++;
      $display("[TB] FAIL rx_ready_timeout: got %b expected 1", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit isData, input int maxGap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, maxGap)) @(negedge clk);
      sendByte(w[8*i +: 8]);
      if (isData) benchCsum = benchCsum ^ w[8*i +: 8];
    end
  endtask

  task automatic sendCsum();
`ifdef INST_LOADER_CHECKSUM_EN
    sendByte(benchCsum);
`endif
  endtask

  task automatic test_reset();
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    vecCnt++; if (busy !== 1'b0) begin missCnt++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vecCnt++; if (done !== 1'b0) begin missCnt++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vecCnt++; if (error !== 1'b0) begin missCnt++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
    vecCnt++; if (bus.rx_ready !== 1'b0) begin missCnt++; $display("[TB] FAIL reset_rx_ready: got %b expected 0", bus.rx_ready); end
    vecCnt++; if (bus.mem_we !== 1'b0) begin missCnt++; $display("[TB] FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    vecCnt++; if (bus.mem_addr !== '0) begin missCnt++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    vecCnt++; if (bus.mem_di !== 32'h0) begin missCnt++; $display("[TB] FAIL reset_mem_di: got %h expected 0", bus.mem_di); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_words();
    int base = weAddr.size();
    logic [31:0] expData[2] = '{32'h00000013, 32'h00100093};
    benchCsum = 8'h00;
    pulseStart();
    sendWord(32'd2, 1'b0, 0);
    sendWord(expData[0], 1'b1, 0);
    pulseStart();
    sendWord(expData[1], 1'b1, 0);
    vecCnt++; if (bus.mem_we !== 1'b1) begin missCnt++; $display("[TB] FAIL wrlast_mem_we: got %b expected 1", bus.mem_we); end
    vecCnt++; if (bus.rx_ready !== 1'b0) begin missCnt++; $display("[TB] FAIL wrlast_rx_ready: got %b expected 0", bus.rx_ready); end
    vecCnt++; if (done !== 1'b0) begin missCnt++; $display("[TB] FAIL wrlast_done: got %b expected 0", done); end
    @(negedge clk);
    sendCsum();
    vecCnt++; if (done !== 1'b1) begin missCnt++; $display("[TB] FAIL two_done: got %b expected 1", done); end
    vecCnt++; if (busy !== 1'b0) begin missCnt++; $display("[TB] FAIL two_busy: got %b expected 0", busy); end
    vecCnt++; if (weAddr.size() - base !== 2) begin missCnt++; $display("[TB] FAIL two_write_count: got %0d expected 2", weAddr.size() - base); end
    for (int i = 0; i < 2 && base + i < weAddr.size(); i++) begin
      vecCnt++; if (weAddr[base+i] !== ADDR_W'(i)) begin missCnt++; $display("[TB] FAIL two_addr%0d: got %h expected %h", i, weAddr[base+i], i); end
      vecCnt++; if (weData[base+i] !== expData[i]) begin missCnt++; $display("[TB] FAIL two_data%0d: got %h expected %h", i, weData[base+i], expData[i]); end
    end
    repeat (5) @(negedge clk);
    vecCnt++; if (done !== 1'b1) begin missCnt++; $display("[TB] FAIL two_done_hold: got %b expected 1", done); end
    vecCnt++; if (bus.mem_addr !== ADDR_W'(1)) begin missCnt++; $display("[TB] FAIL two_addr_hold: got %h expected 001", bus.mem_addr); end
    vecCnt++; if (bus.mem_di !== expData[1]) begin missCnt++; $display("[TB] FAIL two_di_hold: got %h expected %h", bus.mem_di, expData[1]); end
  endtask

  task automatic test_zero_len();
    int base = weAddr.size();
    benchCsum = 8'h00;
    pulseStart();
    vecCnt++; if (done !== 1'b0) begin missCnt++; $display("[TB] FAIL zero_done_cleared: got %b expected 0", done); end
    sendWord(32'd0, 1'b0, 0);
`ifdef INST_LOADER_CHECKSUM_EN
    vecCnt++; if (bus.rx_ready !== 1'b1) begin missCnt++; $display("[TB] FAIL zero_csum_ready: got %b expected 1", bus.rx_ready); end
    sendCsum();
`else
    vecCnt++; if (bus.rx_ready !== 1'b0) begin missCnt++; $display("[TB] FAIL zero_rx_ready: got %b expected 0", bus.rx_ready); end
`endif
    vecCnt++; if (done !== 1'b1) begin missCnt++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
    vecCnt++; if (weAddr.size() - base !== 0) begin missCnt++; $display("[TB] FAIL zero_write_count: got %0d expected 0", weAddr.size() - base); end
  endtask

  task automatic test_oversize();
    int base = weAddr.size();
    pulseStart();
    sendWord(32'd1024, 1'b0, 0);
    vecCnt++; if (busy !== 1'b1) begin missCnt++; $display("[TB] FAIL max_accepted_busy: got %b expected 1", busy); end
    vecCnt++; if (error !== 1'b0) begin missCnt++; $display("[TB] FAIL max_accepted_error: got %b expected 0", error); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    pulseStart();
    sendWord(32'd1025, 1'b0, 0);
    vecCnt++; if (error !== 1'b1) begin missCnt++; $display("[TB] FAIL over_error: got %b expected 1", error); end
    vecCnt++; if (busy !== 1'b0) begin missCnt++; $display("[TB] FAIL over_busy: got %b expected 0", busy); end
    vecCnt++; if (done !== 1'b0) begin missCnt++; $display("[TB] FAIL over_done: got %b expected 0", done); end
    vecCnt++; if (weAddr.size() - base !== 0) begin missCnt++; $display("[TB] FAIL over_write_count: got %0d expected 0", weAddr.size() - base); end
  endtask

  task automatic test_gaps();
    int base = weAddr.size();
    int rep  = weRepeat;
    logic [31:0] expData[3] = '{32'h00000013, 32'h00100093, 32'h00208133};
    benchCsum = 8'h00;
    pulseStart();
    vecCnt++; if (error !== 1'b0) begin missCnt++; $display("[TB] FAIL gap_error_cleared: got %b expected 0", error); end
    sendWord(32'd3, 1'b0, 3);
    for (int w = 0; w < 3; w++) sendWord(expData[w], 1'b1, 3);
    @(negedge clk);
    sendCsum();
    vecCnt++; if (done !== 1'b1) begin missCnt++; $display("[TB] FAIL gap_done: got %b expected 1", done); end
    vecCnt++; if (weAddr.size() - base !== 3) begin missCnt++; $display("[TB] FAIL gap_write_count: got %0d expected 3", weAddr.size() - base); end
    vecCnt++; if (weRepeat !== rep) begin missCnt++; $display("[TB] FAIL gap_we_width: got %0d stretched expected 0", weRepeat - rep); end
    for (int i = 0; i < 3 && base + i < weAddr.size(); i++) begin
      vecCnt++; if (weAddr[base+i] !== ADDR_W'(i)) begin missCnt++; $display("[TB] FAIL gap_addr%0d: got %h expected %h", i, weAddr[base+i], i); end
      vecCnt++; if (weData[base+i] !== expData[i]) begin missCnt++; $display("[TB] FAIL gap_data%0d: got %h expected %h", i, weData[base+i], expData[i]); end
    end
  endtask

  task automatic test_reset_midload();
    int base = weAddr.size();
    benchCsum = 8'h00;
    pulseStart();
    sendWord(32'd2, 1'b0, 0);
    sendWord(32'h11223344, 1'b1, 0);
    sendByte(8'hAA);
    sendByte(8'hBB);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    vecCnt++; if (busy !== 1'b0) begin missCnt++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    vecCnt++; if (bus.mem_we !== 1'b0) begin missCnt++; $display("[TB] FAIL mid_mem_we: got %b expected 0", bus.mem_we); end
    vecCnt++; if (bus.mem_di !== 32'h0) begin missCnt++; $display("[TB] FAIL mid_mem_di: got %h expected 0", bus.mem_di); end
    vecCnt++; if (weAddr.size() - base !== 1) begin missCnt++; $display("[TB] FAIL mid_write_count: got %0d expected 1", weAddr.size() - base); end
    rstn = 1'b1;
    @(negedge clk);
    base = weAddr.size();
    benchCsum = 8'h00;
    pulseStart();
    sendWord(32'd1, 1'b0, 0);
    sendWord(32'hDEADBEEF, 1'b1, 0);
    @(negedge clk);
    sendCsum();
    vecCnt++; if (done !== 1'b1) begin missCnt++; $display("[TB] FAIL fresh_done: got %b expected 1", done); end
    vecCnt++; if (weAddr.size() - base !== 1) begin missCnt++; $display("[TB] FAIL fresh_write_count: got %0d expected 1", weAddr.size() - base); end
    if (weAddr.size() > base) begin
      vecCnt++; if (weAddr[base] !== '0) begin missCnt++; $display("[TB] FAIL fresh_addr: got %h expected 000", weAddr[base]); end
      vecCnt++; if (weData[base] !== 32'hDEADBEEF) begin missCnt++; $display("[TB] FAIL fresh_data: got %h expected deadbeef", weData[base]); end
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] sums[2] = '{8'h22, 8'h23};
    for (int k = 0; k < 2; k++) begin
      benchCsum = 8'h00;
      pulseStart();
      sendWord(32'd1, 1'b0, 0);
      sendWord(32'hDEADBEEF, 1'b1, 0);
      @(negedge clk);
      sendByte(sums[k]);
      vecCnt++; if (done !== (k == 0)) begin missCnt++; $display("[TB] FAIL csum%0d_done: got %b expected %b", k, done, k == 0); end
      vecCnt++; if (error !== (k == 1)) begin missCnt++; $display("[TB] FAIL csum%0d_error: got %b expected %b", k, error, k == 1); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_oversize();
    test_gaps();
    test_reset_midload();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted program length in words.
REQ-003 Clocking: one clock, clk; reset rstn is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rstn  in  1  synchronous active-low reset.
REQ-006 start  in  1  single-cycle pulse that begins a load.
REQ-007 rx_data  in  8  byte from the UART receiver.
REQ-008 rx_valid  in  1  rx_data is valid this cycle.
REQ-009 rx_ready  out  1  loader accepts the byte; a byte transfers when rx_valid and rx_ready are both 1.
REQ-010 mem_we  out  1  instruction-memory write enable.
REQ-011 mem_addr  out  ADDR_W  instruction-memory word address.
REQ-012 mem_di  out  32  instruction-memory write data.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  load completed successfully; held until the next start or reset.
REQ-015 error  out  1  load aborted; held until the next start or reset.

Function
REQ-016 States: IDLE, HDR, DATA, WR_LAST, CSUM (macro only), DONE, ERR.
REQ-017 IDLE/DONE/ERR + start -> HDR; clear done, error, byte counter, word counter and checksum.
REQ-018 start in HDR/DATA/WR_LAST/CSUM shall be ignored.
REQ-019 rx_ready=1 only in HDR, DATA, CSUM; busy=1 in HDR, DATA, WR_LAST, CSUM.
REQ-020 HDR: accept 4 bytes, little-endian (first byte -> bits 7:0), forming word count N.
REQ-021 After the 4th header byte: N=0 -> DONE (or CSUM with the macro); N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-022 DATA: assemble 4 bytes per word, little-endian.
REQ-023 Accepting a word's 4th byte on cycle t shall register mem_di and mem_addr=word index (0-based) and pulse mem_we for exactly one cycle at t+1.
REQ-024 Bytes of the next word are accepted during the mem_we cycle without stall; mem_di stays stable while mem_we=1.
REQ-025 After the N-th word's 4th byte -> WR_LAST (mem_we pulse cycle, rx_ready=0) -> DONE, or -> CSUM with the macro; done=1 from t+2.
REQ-026 mem_addr shall never exceed N-1; there is no wrap-around because N<=MAX_WORDS.
REQ-027 In IDLE, DONE and ERR: mem_we=0; mem_addr and mem_di hold their last values.

Reset
REQ-028 rstn=0 on any edge -> IDLE; mem_we, rx_ready, busy, done, error=0; mem_addr, mem_di, counters and checksum=0.
REQ-029 Reset mid-load shall abort without completing a pending write; memory contents already written are left as is.

Configuration
REQ-030 Macro INST_LOADER_CHECKSUM_EN defined: keep a running XOR of all DATA bytes; after the last word (or after the header when N=0), CSUM accepts one byte; match -> DONE, mismatch -> ERR, in the cycle after acceptance.
REQ-031 Macro undefined: no CSUM state and no checksum logic; the load completes as in REQ-025.

Structure
REQ-032 Package inst_loader_pkg shall hold the state enum, HDR_BYTES=4, BYTES_PER_WORD=4 and the default MAX_WORDS.
REQ-033 Sub-module word_assembler: 8-to-32 little-endian shift/pack with byte index and word_valid pulse; instantiated for both header and data.

Verification
REQ-034 Header 02 00 00 00, data 13 00 00 00 / 93 00 10 00 -> mem_we pulses: addr 0 di 0x00000013, addr 1 di 0x00100093; done=1.
REQ-035 Header 00 00 00 00 -> no mem_we; done=1 (macro off), rx_ready=0 after the 4th byte.
REQ-036 Header 01 04 00 00 (N=1025) -> error=1, no mem_we, busy=0.
REQ-037 rx_valid with gaps of 0-3 random idle cycles, N=3 -> same writes as the gapless case, each mem_we exactly one cycle.
REQ-038 rstn low after 6 data bytes, then start and a fresh N=1 load of 0xDEADBEEF -> single write, addr 0 di 0xDEADBEEF, done=1.
REQ-039 Macro on, N=1, bytes EF BE AD DE, checksum 0x22 -> done; checksum 0x23 -> error.
